// File: rtl/lightgun_pkg.sv
// lightgun_pkg: shared types and constants for the light-gun array.
// Trigger FSM states, light levels, offscreen margins and decode helpers.
package lightgun_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    LOCKOUT,
    WAIT_REL
  } trig_state_t;

  localparam logic [4:0] LIGHT_WHITE  = 5'd26;
  localparam logic [4:0] LIGHT_BRIGHT = 5'd20;
  localparam logic [4:0] LIGHT_MID    = 5'd17;

  localparam int OFF_LEFT   = 1;
  localparam int OFF_RIGHT  = 2;
  localparam int OFF_TOP    = 8;
  localparam int OFF_BOTTOM = 16;

  function automatic logic [10:0] abs11(
    input logic signed [10:0] v
  );
    return v[10] ? 11'(-v) : 11'(v);
  endfunction

  // Zero means the colour does not load the counter.
  function automatic logic [4:0] light_level(
    input logic [5:0] c
  );
    logic [4:0] l;
    l = 5'd0;
    unique case (1'b1)
      (c == 6'h20 || c == 6'h30):
        l = LIGHT_WHITE;
      (c == 6'h10 || (c >= 6'h31 && c <= 6'h3d)):
        l = LIGHT_BRIGHT;
      (c == 6'h00 || (c >= 6'h21 && c <= 6'h2d)):
        l = LIGHT_MID;
      default:
        l = 5'd0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/lightgun_channel.sv
// lightgun_channel: one gun -- aim, reticle, light sense, trigger FSM.
// LIGHTGUN_AUTOFIRE_EN adds the autofire input and re-fire from LOCKOUT.
module lightgun_channel
  import lightgun_pkg::*;
#(
  parameter int CROSS_SIZE   = 4,
  parameter int LIGHT_RADIUS = 4,
  parameter int TRIG_ACTIVE  = 830_000,
  parameter int TRIG_LOCKOUT = 2_100_000,
  parameter int SCREEN_W     = 256,
  parameter int SCREEN_H     = 240
) (
  input  logic        clk,
  input  logic        live,
  input  logic        vde_rise,
  input  logic        line_chg,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic [7:0]  speed,
  input  logic [15:0] analog,
  input  logic        btn,
`ifdef LIGHTGUN_AUTOFIRE_EN
  input  logic        autofire,
`endif
  input  logic [8:0]  cycle,
  input  logic [8:0]  scanline,
  input  logic [5:0]  color,
  output logic        reticle_hit,
  output logic        reticle_off,
  output logic        light,
  output logic        trigger
);

  logic [8:0]  pos_x, pos_y;
  logic [8:0]  nx_x, nx_y;
  logic [9:0]  sum_x, sum_y;
  logic [15:0] an_q;
  logic [4:0]  light_cnt, lc_nx, lvl;
  logic [31:0] cnt, cnt_nx;
  logic signed [10:0] dx, dy;
  logic [10:0] adx, ady;
  logic        off, hit_c, in_win, trig_c, refire;
  trig_state_t state, state_nx;

  assign dx = $signed({2'b00, cycle}) - $signed({2'b00, pos_x});
  assign dy = $signed({2'b00, scanline}) - $signed({2'b00, pos_y});
  assign adx = abs11(dx);
  assign ady = abs11(dy);

  assign off = pos_x <= 9'(OFF_LEFT)
            || pos_x >= 9'(SCREEN_W - OFF_RIGHT)
            || pos_y <= 9'(OFF_TOP)
            || pos_y >= 9'(SCREEN_H - OFF_BOTTOM);

  assign hit_c = (ady == 11'd0 && adx <= 11'(CROSS_SIZE))
              || (adx == 11'd0 && ady <= 11'(CROSS_SIZE));

  assign in_win = adx <= 11'(LIGHT_RADIUS)
               && ady <= 11'(LIGHT_RADIUS) && !off;

  assign lvl = light_level(color);

`ifdef LIGHTGUN_AUTOFIRE_EN
  assign refire = btn & autofire;
`else
  assign refire = 1'b0;
`endif

  always_comb begin
    sum_x = {1'b0, pos_x} + {2'b00, speed};
    sum_y = {1'b0, pos_y} + {2'b00, speed};
    nx_x  = pos_x;
    nx_y  = pos_y;
    if (analog != an_q) begin
      nx_x = {1'b0, analog[7:0]};
      nx_y = {1'b0, analog[15:8]};
    end else begin
      if (right)
        nx_x = (sum_x > 10'(SCREEN_W - 1)) ?
               9'(SCREEN_W - 1) : sum_x[8:0];
      else if (left)
        nx_x = (pos_x > {1'b0, speed}) ?
               pos_x - {1'b0, speed} : 9'd0;
      if (down)
        nx_y = (sum_y > 10'(SCREEN_H)) ?
               9'(SCREEN_H) : sum_y[8:0];
      else if (up)
        nx_y = (pos_y > {1'b0, speed}) ?
               pos_y - {1'b0, speed} : 9'd0;
    end
  end

  // A colour load takes priority over the per-line decay.
  always_comb begin
    lc_nx = light_cnt;
    if (in_win && lvl != 5'd0)
      lc_nx = (lvl > light_cnt) ? lvl : light_cnt;
    else if (line_chg && light_cnt != 5'd0)
      lc_nx = light_cnt - 5'd1;
  end

  always_ff @(posedge clk) begin
    if (!live) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE:
        if (btn) begin
          state_nx = FIRE;
          cnt_nx   = 32'(TRIG_ACTIVE - 1);
        end
      FIRE:
        if (cnt == '0) begin
          state_nx = LOCKOUT;
          cnt_nx   = 32'(TRIG_LOCKOUT - 1);
        end else begin
          cnt_nx = cnt - 32'd1;
        end
      LOCKOUT:
        if (cnt != '0) begin
          cnt_nx = cnt - 32'd1;
        end else if (refire) begin
          state_nx = FIRE;
          cnt_nx   = 32'(TRIG_ACTIVE - 1);
        end else if (btn) begin
          state_nx = WAIT_REL;
        end else begin
          state_nx = IDLE;
        end
      WAIT_REL:
        if (!btn) state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_comb begin
    trig_c = (state == FIRE);
  end

  always_ff @(posedge clk) begin
    if (!live) begin
      pos_x       <= '0;
      pos_y       <= '0;
      an_q        <= '0;
      light_cnt   <= '0;
      reticle_hit <= 1'b0;
      reticle_off <= 1'b0;
      light       <= 1'b0;
      trigger     <= 1'b0;
    end else begin
      if (vde_rise) begin
        pos_x <= nx_x;
        pos_y <= nx_y;
        an_q  <= analog;
      end
      light_cnt   <= lc_nx;
      reticle_hit <= hit_c;
      reticle_off <= off;
      light       <= (lc_nx == 5'd0);
      trigger     <= trig_c;
    end
  end

endmodule

// File: rtl/lightgun_array.sv
// lightgun_array: NUM_GUNS Zapper channels sharing one PPU pixel stream.
// Define LIGHTGUN_AUTOFIRE_EN to add the per-gun autofire input.
module lightgun_array
  import lightgun_pkg::*;
#(
  parameter int NUM_GUNS     = 2,
  parameter int CROSS_SIZE   = 4,
  parameter int LIGHT_RADIUS = 4,
  parameter int TRIG_ACTIVE  = 830_000,
  parameter int TRIG_LOCKOUT = 2_100_000,
  parameter int SCREEN_W     = 256,
  parameter int SCREEN_H     = 240
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_GUNS-1:0]    gun_enable,
  input  logic [NUM_GUNS-1:0]    dpad_up,
  input  logic [NUM_GUNS-1:0]    dpad_down,
  input  logic [NUM_GUNS-1:0]    dpad_left,
  input  logic [NUM_GUNS-1:0]    dpad_right,
  input  logic [8*NUM_GUNS-1:0]  aim_speed,
  input  logic [16*NUM_GUNS-1:0] analog,
  input  logic [NUM_GUNS-1:0]    trigger_btn,
`ifdef LIGHTGUN_AUTOFIRE_EN
  input  logic [NUM_GUNS-1:0]    autofire,
`endif
  input  logic [8:0]             cycle,
  input  logic [8:0]             scanline,
  input  logic                   vde,
  input  logic [5:0]             color,
  output logic [NUM_GUNS-1:0]    reticle_hit,
  output logic [NUM_GUNS-1:0]    reticle_off,
  output logic [NUM_GUNS-1:0]    light,
  output logic [NUM_GUNS-1:0]    trigger
);

  logic       vde_q;
  logic [8:0] line_q;
  logic       vde_rise, line_chg;

  always_ff @(posedge clk) begin
    if (reset) begin
      vde_q  <= 1'b0;
      line_q <= '0;
    end else begin
      vde_q  <= vde;
      line_q <= scanline;
    end
  end

  assign vde_rise = vde & ~vde_q;
  assign line_chg = (scanline != line_q);

  for (genvar g = 0; g < NUM_GUNS; g++) begin : g_gun
    lightgun_channel #(
      .CROSS_SIZE   (CROSS_SIZE),
      .LIGHT_RADIUS (LIGHT_RADIUS),
      .TRIG_ACTIVE  (TRIG_ACTIVE),
      .TRIG_LOCKOUT (TRIG_LOCKOUT),
      .SCREEN_W     (SCREEN_W),
      .SCREEN_H     (SCREEN_H)
    ) u_ch (
      .clk         (clk),
      .live        (gun_enable[g] & ~reset),
      .vde_rise    (vde_rise),
      .line_chg    (line_chg),
      .up          (dpad_up[g]),
      .down        (dpad_down[g]),
      .left        (dpad_left[g]),
      .right       (dpad_right[g]),
      .speed       (aim_speed[8*g +: 8]),
      .analog      (analog[16*g +: 16]),
      .btn         (trigger_btn[g]),
`ifdef LIGHTGUN_AUTOFIRE_EN
      .autofire    (autofire[g]),
`endif
      .cycle       (cycle),
      .scanline    (scanline),
      .color       (color),
      .reticle_hit (reticle_hit[g]),
      .reticle_off (reticle_off[g]),
      .light       (light[g]),
      .trigger     (trigger[g])
    );
  end

endmodule

// File: tb/tb_lightgun_array.sv
// tb_lightgun_array: scoreboard bench with a behavioural gun model.
// Expected outputs are queued per clock and checked by a monitor.
module tb_lightgun_array;

  localparam int N  = 2;
  localparam int CS = 4;
  localparam int LR = 4;
  localparam int TA = 10;
  localparam int TL = 20;
  localparam int SW = 256;
  localparam int SH = 240;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [N-1:0]  gun_enable, dpad_up, dpad_down, dpad_left, dpad_right;
  logic [8*N-1:0]  aim_speed;
  logic [16*N-1:0] analog;
  logic [N-1:0]  trigger_btn;
`ifdef LIGHTGUN_AUTOFIRE_EN
  logic [N-1:0]  autofire;
`endif
  logic [8:0]    cycle, scanline;
  logic          vde;
  logic [5:0]    color;
  logic [N-1:0]  reticle_hit, reticle_off, light, trigger;

  lightgun_array #(
    .NUM_GUNS(N), .CROSS_SIZE(CS), .LIGHT_RADIUS(LR),
    .TRIG_ACTIVE(TA), .TRIG_LOCKOUT(TL),
    .SCREEN_W(SW), .SCREEN_H(SH)
  ) dut (
    .clk(clk), .reset(reset), .gun_enable(gun_enable),
    .dpad_up(dpad_up), .dpad_down(dpad_down),
    .dpad_left(dpad_left), .dpad_right(dpad_right),
    .aim_speed(aim_speed), .analog(analog),
    .trigger_btn(trigger_btn),
`ifdef LIGHTGUN_AUTOFIRE_EN
    .autofire(autofire),
`endif
    .cycle(cycle), .scanline(scanline), .vde(vde), .color(color),
    .reticle_hit(reticle_hit), .reticle_off(reticle_off),
    .light(light), .trigger(trigger)
  );

  typedef struct packed {
    logic [N-1:0] hit;
    logic [N-1:0] off;
    logic [N-1:0] lit;
    logic [N-1:0] trg;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int n_vec = 0;
  int n_bad = 0;

  // model state
  int px[N], py[N], anp[N], lc[N], shot[N];
  bit shv[N], nrel[N];
  int vprev = 0, sprev = 0, tnow = 0;

  function automatic int lvl_of(int c);
    if (c == 'h20 || c == 'h30) return 26;
    if (c == 'h10 || (c >= 'h31 && c <= 'h3d)) return 20;
    if (c == 'h00 || (c >= 'h21 && c <= 'h2d)) return 17;
    return 0;
  endfunction

  function automatic int iabs(int v);
    return v < 0 ? -v : v;
  endfunction

  task automatic model();
    exp_t e;
    bit rise, lchg, live, btn, af, off;
    int adx, ady, lvl, an, sp;
    e = '0;
    rise = vde && (vprev == 0);
    lchg = (int'(scanline) != sprev);
    for (int g = 0; g < N; g++) begin
      live = gun_enable[g] && !reset;
      if (!live) begin
        px[g] = 0; py[g] = 0; anp[g] = 0; lc[g] = 0;
        shv[g] = 0; nrel[g] = 0;
        continue;
      end
      adx = iabs(int'(cycle) - px[g]);
      ady = iabs(int'(scanline) - py[g]);
      off = px[g] <= 1 || px[g] >= SW - 2 ||
            py[g] <= 8 || py[g] >= SH - 16;
      e.hit[g] = (ady == 0 && adx <= CS) || (adx == 0 && ady <= CS);
      e.off[g] = off;
      lvl = lvl_of(int'(color));
      if (adx <= LR && ady <= LR && !off && lvl > 0) begin
        if (lvl == 26) lc[g] = 26;
        else if (lc[g] < lvl) lc[g] = lvl;
      end else if (lchg && lc[g] > 0) begin
        lc[g]--;
      end
      e.lit[g] = (lc[g] == 0);
      btn = trigger_btn[g];
`ifdef LIGHTGUN_AUTOFIRE_EN
      af = autofire[g];
`else
      af = 1'b0;
`endif
      if (shv[g] && tnow == shot[g] + TA + TL) begin
        if (btn && af) shot[g] = tnow;
        else if (btn) nrel[g] = 1;
      end else if (!shv[g] || tnow > shot[g] + TA + TL) begin
        if (nrel[g]) begin
          if (!btn) nrel[g] = 0;
        end else if (btn) begin
          shot[g] = tnow;
          shv[g] = 1;
        end
      end
      e.trg[g] = shv[g] && tnow >= shot[g] + 1 && tnow <= shot[g] + TA;
      if (rise) begin
        an = int'(analog[16*g +: 16]);
        sp = int'(aim_speed[8*g +: 8]);
        if (an != anp[g]) begin
          px[g] = an & 255;
          py[g] = an >> 8;
        end else begin
          if (dpad_right[g]) px[g] = (px[g] + sp > SW - 1) ? SW - 1 : px[g] + sp;
          else if (dpad_left[g]) px[g] = (px[g] - sp < 0) ? 0 : px[g] - sp;
          if (dpad_down[g]) py[g] = (py[g] + sp > SH) ? SH : py[g] + sp;
          else if (dpad_up[g]) py[g] = (py[g] - sp < 0) ? 0 : py[g] - sp;
        end
        anp[g] = an;
      end
    end
    vprev = reset ? 0 : int'(vde);
    sprev = reset ? 0 : int'(scanline);
    tnow++;
    exp_q.push_back(e);
  endtask

  task automatic chk(string nm, logic [N-1:0] a, logic [N-1:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s t=%0t got %b want %b", nm, $time, a, e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("reticle_hit", reticle_hit, mon_e.hit);
      chk("reticle_off", reticle_off, mon_e.off);
      chk("light", light, mon_e.lit);
      chk("trigger", trigger, mon_e.trg);
    end
  end

  task automatic cyc();
    model();
    @(negedge clk);
  endtask

  task automatic vde_pulse();
    vde = 1'b0; cyc();
    vde = 1'b1; cyc();
    cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int g, t;
    reset = 1'b1; gun_enable = '0;
    dpad_up = '0; dpad_down = '0; dpad_left = '0; dpad_right = '0;
    aim_speed = '0; analog = '0; trigger_btn = '0;
`ifdef LIGHTGUN_AUTOFIRE_EN
    autofire = '0;
`endif
    cycle = '0; scanline = '0; vde = 1'b0; color = 6'h0f;
    repeat (3) cyc();
    reset = 1'b0; gun_enable = 2'b11;
    cyc();
    // distinct aims
    analog = {16'h3060, 16'h4080};
    vde_pulse();
    for (int d = -6; d <= 6; d++) begin
      cycle = 9'(8'h80 + d); scanline = 9'h40; cyc();
    end
    for (int d = -6; d <= 6; d++) begin
      cycle = 9'h80; scanline = 9'(8'h40 + d); cyc();
    end
    // white light, then decay over scanline changes
    cycle = 9'h80; scanline = 9'h40; color = 6'h30; cyc();
    color = 6'h0f; cycle = 9'h0;
    for (int i = 0; i < 30; i++) begin
      scanline = scanline + 9'd1; cyc(); cyc();
    end
    cycle = 9'h80; scanline = 9'h42; color = 6'h21; cyc();
    color = 6'h0f; cycle = 9'h0;
    for (int i = 0; i < 20; i++) begin
      scanline = scanline + 9'd1; cyc();
    end
    // trigger: press, ignored press at 15, press at 31
    trigger_btn = 2'b01; cyc(); trigger_btn = 2'b00;
    repeat (14) cyc();
    trigger_btn = 2'b01; cyc(); trigger_btn = 2'b00;
    repeat (15) cyc();
    trigger_btn = 2'b01; cyc(); trigger_btn = 2'b00;
    repeat (40) cyc();
    trigger_btn = 2'b01; repeat (70) cyc();
    trigger_btn = 2'b00; repeat (5) cyc();
`ifdef LIGHTGUN_AUTOFIRE_EN
    autofire = 2'b01; trigger_btn = 2'b01; repeat (100) cyc();
    autofire = 2'b00; trigger_btn = 2'b00; repeat (35) cyc();
`endif
    // near-zero aim: signed differences
    analog[15:0] = 16'h4002; vde_pulse();
    scanline = 9'h40;
    for (int c = 0; c < 9; c++) begin
      cycle = 9'(c); cyc();
    end
    cycle = 9'h1fe; cyc();
    // saturation at the right and bottom edges
    analog[15:0] = 16'h40ff; vde_pulse();
    dpad_right = 2'b01; dpad_down = 2'b10;
    aim_speed = {8'd200, 8'd8};
    vde_pulse(); vde_pulse();
    dpad_right = 2'b00; dpad_down = 2'b00;
    for (int c = 250; c < 260; c++) begin
      cycle = 9'(c); scanline = 9'h40; cyc();
    end
    dpad_up = 2'b10; vde_pulse(); dpad_up = 2'b00;
    // gun 1 disabled mid-shot
    analog = {16'h5070, 16'h4080}; vde_pulse();
    trigger_btn = 2'b11; cyc(); trigger_btn = 2'b00;
    repeat (4) cyc();
    gun_enable = 2'b01; repeat (3) cyc();
    gun_enable = 2'b11; repeat (40) cyc();
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 499) == 0);
      for (int k = 0; k < N; k++) begin
        gun_enable[k] = ($urandom_range(0, 199) != 0);
        if ($urandom_range(0, 9) == 0) trigger_btn[k] = ~trigger_btn[k];
        if ($urandom_range(0, 7) == 0) analog[16*k +: 16] = 16'($urandom);
        if ($urandom_range(0, 15) == 0)
          aim_speed[8*k +: 8] = ($urandom_range(0, 3) == 0) ?
                                8'($urandom) : 8'($urandom_range(0, 15));
      end
      dpad_up = N'($urandom); dpad_down = N'($urandom);
      dpad_left = N'($urandom); dpad_right = N'($urandom);
`ifdef LIGHTGUN_AUTOFIRE_EN
      if ($urandom_range(0, 31) == 0) autofire = N'($urandom);
`endif
      if ($urandom_range(0, 7) == 0) vde = ~vde;
      g = int'($urandom_range(0, N - 1));
      if ($urandom_range(0, 3) == 0) begin
        cycle = 9'($urandom); scanline = 9'($urandom);
      end else begin
        t = px[g] + int'($urandom_range(0, 12)) - 6;
        cycle = 9'(t);
        t = py[g] + int'($urandom_range(0, 12)) - 6;
        scanline = 9'(t);
      end
      color = 6'($urandom);
      cyc();
    end
    reset = 1'b0;
    @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lightgun_array.md
# lightgun_array

Multi-channel NES light-gun emulator: `NUM_GUNS` independent Zapper-style channels share one PPU pixel stream and each derive aim position, reticle overlay, light-sense and trigger outputs. It sits between the input mapper (d-pad and analog sticks per player) and the controller-port serialiser / video overlay mixer. It generalises the single-gun block: gun count, trigger timing, screen bounds and hit window are parameters. It adds an explicit trigger state machine and wrap-free window arithmetic.

## Interface
- `NUM_GUNS`, 2: number of independent gun channels (1–4).
- `CROSS_SIZE`, 4: reticle arm half-length, pixels.
- `LIGHT_RADIUS`, 4: half-size of the square light-sense window, pixels.
- `TRIG_ACTIVE`, 830_000: clocks `trigger` is held high per shot.
- `TRIG_LOCKOUT`, 2_100_000: clocks after a shot before re-arming.
- `SCREEN_W`, 256 / `SCREEN_H`, 240: aim clamp bounds.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `gun_enable` in NUM_GUNS: per-channel enable.
- `dpad_up`, `dpad_down`, `dpad_left`, `dpad_right` in NUM_GUNS each: digital aim.
- `aim_speed` in 8×NUM_GUNS: pixels per frame of d-pad motion, packed with gun 0 in the LSBs.
- `analog` in 16×NUM_GUNS: per gun, [7:0]=x and [15:8]=y absolute aim.
- `trigger_btn` in NUM_GUNS: raw trigger buttons.
- `autofire` in NUM_GUNS: present only with `LIGHTGUN_AUTOFIRE_EN`.
- `cycle`, `scanline` in 9 each: current PPU pixel.
- `vde` in 1: visible-area enable.
- `color` in 6: NES palette index of the current pixel.
- `reticle_hit` out NUM_GUNS: pixel lies on that gun's crosshair.
- `reticle_off` out NUM_GUNS: the aim point is offscreen.
- `light` out NUM_GUNS: active-low light sense.
- `trigger` out NUM_GUNS: trigger pulled.

## Operation
- A channel is live only when `gun_enable[i]` is high and `reset` is low. A non-live channel clears all of its state. Its `light`, `trigger`, `reticle_hit` and `reticle_off` outputs are all 0.
- **Aim update.** Aim updates once per frame, on the rising edge of `vde`.
  - If `analog` differs from the value sampled at the previous edge, `pos` loads the absolute x/y.
  - Otherwise the d-pad moves `pos` by `aim_speed`. The result saturates to x∈[0,SCREEN_W−1] and y∈[0,SCREEN_H].
  - Left and right pressed together: right wins. Up and down pressed together: down wins.
- **Window arithmetic.** Differences `cycle−pos_x` and `scanline−pos_y` are computed as 11-bit signed values, with no unsigned wrap.
  - `reticle_hit` = (|dy|==0 and |dx|≤CROSS_SIZE) or (|dx|==0 and |dy|≤CROSS_SIZE).
  - `reticle_off` = pos_x≤1 or pos_x≥SCREEN_W−2 or pos_y≤8 or pos_y≥SCREEN_H−16.
- **Light sense.** A pixel is in the window when |dx|≤LIGHT_RADIUS and |dy|≤LIGHT_RADIUS, and the aim is not offscreen.
  - Colour 0x20/0x30: set `light_cnt` = 26 unconditionally.
  - Colour 0x31–0x3D or 0x10: set `light_cnt` = max(cnt, 20).
  - Colour 0x21–0x2D or 0x00: set `light_cnt` = max(cnt, 17).
  - Any other colour: no load.
  - `light_cnt` decrements by 1 on each `scanline` change when nonzero. A load in the same cycle as a decrement wins.
  - `light` = ~(light_cnt≠0).
- **Trigger FSM per channel** (states IDLE, FIRE, LOCKOUT, WAIT_REL):
  - IDLE: on `trigger_btn` high, load the counter with TRIG_ACTIVE−1 and go to FIRE.
  - FIRE: `trigger`=1. When the counter reaches 0, load TRIG_LOCKOUT−1 and go to LOCKOUT.
  - LOCKOUT: when the counter reaches 0, go to IDLE if the button is released, otherwise to WAIT_REL.
  - WAIT_REL: go to IDLE on button release.
  - A button press during FIRE or LOCKOUT is ignored.

## Timing
- Every output is registered, with one clock of latency from `cycle`/`scanline`/`color`.
- Reset values: all outputs 0, `pos` = 0, FSM = IDLE, counters = 0.
- `trigger` rises on the clock after the IDLE→FIRE edge. It is high for exactly TRIG_ACTIVE clocks.
- The earliest next shot is TRIG_ACTIVE+TRIG_LOCKOUT clocks after the previous one.
- `pos` changes one clock after the `vde` rising edge and is stable for the rest of the frame.
- Deasserting `gun_enable` mid-shot drops `trigger` on the next clock. Re-enabling restarts in IDLE with `pos` = 0.

## Configuration
- `LIGHTGUN_AUTOFIRE_EN` defined:
  - The `autofire` port exists.
  - In LOCKOUT, with the counter at 0 and both `trigger_btn` and `autofire` high, the FSM goes directly to FIRE, re-firing every TRIG_ACTIVE+TRIG_LOCKOUT clocks while the button is held.
- Not defined: the `autofire` port is absent, and a held button produces exactly one shot.

## Structure
- `lightgun_pkg` holds:
  - the `trig_state_t` enum (IDLE, FIRE, LOCKOUT, WAIT_REL);
  - the light levels `LIGHT_WHITE`=26, `LIGHT_BRIGHT`=20, `LIGHT_MID`=17;
  - the offscreen margin constants.
- Sub-module `lightgun_channel` implements one gun. The top level instantiates it NUM_GUNS times and registers the shared pixel inputs once.

## Test plan
- Gun 0 analog=0x4080 then `vde` rising edge → pos=(0x80,0x40) and `reticle_off`=0. Pixel (0x80,0x40) → `reticle_hit[0]`=1.
- Trigger press for 1 clock with small TRIG_ACTIVE=10 and TRIG_LOCKOUT=20 → `trigger` high for 10 clocks. A second press 15 clocks later is ignored. A press at 31 fires.
- Held button without the macro → one 10-clock pulse, then WAIT_REL. With the macro and `autofire`=1 → pulses every 30 clocks.
- Colour 0x30 inside the window → `light`=0 for 26 scanline changes, then 1. Colour 0x21 after that → 17.
- pos_x=2, cycle=0 (wrap case) → dx=−2, so `reticle_hit` matches the signed math. pos_x=255 with d-pad right, speed 8 → pos saturates at 255.
- Two guns with distinct aims, and gun 1 disabled mid-FIRE → gun 1 outputs go to 0 the next clock while gun 0 is unaffected.
